mux_rr_nch: RTL and testbench

MUX_RR_NCH -- requirements
Module: mux_rr_nch

---
 rtl/mux_rr_nch.sv | 132 +++++++++++++
 tb/tb_mux_rr_nch.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_nch.sv
// ---------------------------------------------------------------------------
// mux_rr_nch
//   N-channel to one registered output multiplexer with valid/ready
//   handshakes on both sides. Each cycle at most one input channel is
//   granted and its word is captured into the output register.
//
//   Build option:
//     MUX_RR_NCH_RR_EN defined   -> round-robin grant. The search starts one
//                                   past the last granted channel.
//     MUX_RR_NCH_RR_EN undefined -> fixed priority. The lowest index wins.
//   Both builds have the same ports, latency and handshake.
//
//   Handshake: a word moves across an interface on every cycle where its
//   valid and ready are both high. On the input side, rdy[i] is the
//   per-channel ready. Input rdy is combinational from v, m_ready and the
//   registered state. The output side (m/m_valid/m_ready) is fully
//   registered.
//
//   Ports:
//     clk      - clock, rising edge
//     reset    - synchronous, active-high reset
//     x        - channel data, channel i at x[i*W +: W]
//     v        - per-channel valid
//     rdy      - per-channel ready; at most one bit high
//     m        - registered output word
//     m_valid  - m holds an unconsumed word
//     m_ready  - downstream accepts m this cycle
//     sel      - index of the channel that sourced m
// ---------------------------------------------------------------------------
module mux_rr_nch #(
    parameter int W = 2,
    parameter int N = 2,
    parameter int S = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*W-1:0] x,
    input  logic [N-1:0]   v,
    output logic [N-1:0]   rdy,
    output logic [W-1:0]   m,
    output logic           m_valid,
    input  logic           m_ready,
    output logic [S-1:0]   sel
);

    logic [W-1:0] r_m;
    logic         r_m_valid;
    logic [S-1:0] r_sel;
`ifdef MUX_RR_NCH_RR_EN
    logic [S-1:0] r_ptr;
`endif

    logic         w_load;
    logic         w_take;
    logic         w_found;
    logic [S-1:0] w_gnt;
    logic [S-1:0] w_cand;
    logic [W-1:0] w_data;

    // The output register can accept a new word when it is empty or is being
    // drained this cycle.
    assign w_load = ~r_m_valid | m_ready;

    // Grant search. The first candidate in search order that has v set wins.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_cand  = '0;
        w_data  = '0;
`ifdef MUX_RR_NCH_RR_EN
        // Search order is ptr+1, ptr+2, ... wrapping mod N. The last visited
        // candidate is ptr itself. This lets a channel that is the only
        // requester win again.
        for (int k = 1; k <= N; k++) begin
            w_cand = S'((int'(r_ptr) + k) % N);
            if (!w_found && v[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
                w_data  = x[int'(w_cand)*W +: W];
            end
        end
`else
        for (int k = 0; k < N; k++) begin
            w_cand = S'(k);
            if (!w_found && v[w_cand]) begin
                w_found = 1'b1;
                w_gnt   = w_cand;
                w_data  = x[int'(w_cand)*W +: W];
            end
        end
`endif
    end

    // Reset blocks the take. This keeps rdy low while reset is held.
    assign w_take = w_load & w_found & ~reset;

    always_comb begin
        rdy = '0;
        if (w_take) begin
            rdy[w_gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m       <= '0;
            r_m_valid <= 1'b0;
            r_sel     <= '0;
`ifdef MUX_RR_NCH_RR_EN
            r_ptr     <= S'(N - 1);
`endif
        end else if (w_load) begin
            if (w_take) begin
                r_m       <= w_data;
                r_sel     <= w_gnt;
                r_m_valid <= 1'b1;
`ifdef MUX_RR_NCH_RR_EN
                r_ptr     <= w_gnt;
`endif
            end else begin
                // Empty or drained with nothing offered. The last word and
                // its index stay visible.
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m       = r_m;
    assign m_valid = r_m_valid;
    assign sel     = r_sel;

endmodule

// File: tb/tb_mux_rr_nch.sv
module tb_mux_rr_nch;
    localparam int W = 8;
    localparam int N = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N*W-1:0] x;
    logic [N-1:0]   v;
    logic [N-1:0]   rdy;
    logic [W-1:0]   m;
    logic           m_valid;
    logic           m_ready;
    logic [S-1:0]   sel;

    mux_rr_nch #(.W(W), .N(N), .S(S)) dut (
        .clk     (clk),
        .reset   (reset),
        .x       (x),
        .v       (v),
        .rdy     (rdy),
        .m       (m),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .sel     (sel)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // scoreboard: {sel, word} of each take, in order
    logic [S+W-1:0] exp_q[$];

    // reference model state
    logic         mdl_valid;
    logic [W-1:0] mdl_m;
    logic [S-1:0] mdl_sel;
    logic [S-1:0] mdl_ptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Returns {found, index}. Round-robin: rotate the request vector so that
    // bit 0 is channel ptr+1, then take the lowest set bit.
    function automatic logic [S:0] mdl_grant(input logic [N-1:0] vv, input logic [S-1:0] p);
        logic [2*N-1:0] dbl;
        logic [N-1:0]   rot;
        int             base;
`ifdef MUX_RR_NCH_RR_EN
        base = (int'(p) + 1) % N;
`else
        base = 0;
`endif
        dbl = {vv, vv};
        rot = N'(dbl >> base);
        for (int j = 0; j < N; j++) begin
            if (rot[j]) return {1'b1, S'((base + j) % N)};
        end
        return '0;
    endfunction

    task automatic mdl_reset();
        mdl_valid = 1'b0;
        mdl_m     = '0;
        mdl_sel   = '0;
        mdl_ptr   = S'(N - 1);
        exp_q.delete();
    endtask

    // One clock cycle with the inputs already driven: check, clock, update model.
    task automatic cycle(input string tag);
        logic         load;
        logic         take;
        logic         found;
        logic [S-1:0] g;
        logic [N-1:0] er;
        logic [S+W-1:0] e;
        #1;
        load = !mdl_valid || m_ready;
        {found, g} = mdl_grant(v, mdl_ptr);
        take = load && found && !reset;
        er = take ? (N'(1) << g) : '0;
        check({tag, "_rdy"}, 32'(rdy), 32'(er));
        check({tag, "_mvalid"}, 32'(m_valid), 32'(mdl_valid));
        check({tag, "_m"}, 32'(m), 32'(mdl_m));
        check({tag, "_sel"}, 32'(sel), 32'(mdl_sel));
        if (!reset && mdl_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                check({tag, "_sb_empty"}, 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check({tag, "_xfer"}, 32'({sel, m}), 32'(e));
            end
        end
        @(posedge clk);
        if (reset) begin
            mdl_reset();
        end else if (load) begin
            if (take) begin
                mdl_m     = x[int'(g)*W +: W];
                mdl_sel   = g;
                mdl_valid = 1'b1;
                mdl_ptr   = g;
                exp_q.push_back({g, mdl_m});
            end else begin
                mdl_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    // driver tasks
    task automatic drive(input logic [N-1:0] vv, input logic mr);
        v       = vv;
        m_ready = mr;
    endtask

    task automatic set_ch(input int ch, input logic [W-1:0] val);
        x[ch*W +: W] = val;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive('0, 1'b0);
        cycle("rst");
        reset = 1'b0;
    endtask

    int fair_seq[5] = '{0, 1, 2, 3, 0};

    initial begin
        reset   = 1'b1;
        x       = '0;
        v       = '0;
        m_ready = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        mdl_reset();
        reset = 1'b0;

        // reset state
        check("reset_mvalid", 32'(m_valid), 32'(0));
        check("reset_m", 32'(m), 32'(0));
        check("reset_sel", 32'(sel), 32'(0));

        // basic take from channel 2
        set_ch(2, 8'hA5);
        drive(4'b0100, 1'b1);
        #1 check("basic_rdy", 32'(rdy), 32'(4'b0100));
        cycle("basic");
        check("basic_m", 32'(m), 32'(8'hA5));
        check("basic_sel", 32'(sel), 32'(2));
        check("basic_mvalid", 32'(m_valid), 32'(1));

        // fairness with all channels requesting
        do_reset();
        for (int c = 0; c < N; c++) set_ch(c, 8'(8'h30 + c));
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, 1'b1);
            cycle("fair");
`ifdef MUX_RR_NCH_RR_EN
            check("fair_seq", 32'(sel), 32'(fair_seq[i]));
`else
            check("fair_seq", 32'(sel), 32'(0));
`endif
            check("fair_mvalid", 32'(m_valid), 32'(1));
        end

        // backpressure
        do_reset();
        set_ch(1, 8'h11);
        drive(4'b0010, 1'b1);
        cycle("bp_load");
        set_ch(1, 8'h22);
        for (int i = 0; i < 5; i++) begin
            drive(4'b0010, 1'b0);
            #1 check("bp_hold_rdy", 32'(rdy), 32'(0));
            cycle("bp");
            check("bp_hold_m", 32'(m), 32'(8'h11));
        end
        drive(4'b0010, 1'b1);
        #1 check("bp_release_rdy", 32'(rdy), 32'(4'b0010));
        cycle("bp_rel");
        check("bp_next_m", 32'(m), 32'(8'h22));

        // drain
        drive(4'b0000, 1'b1);
        cycle("drain");
        check("drain_mvalid", 32'(m_valid), 32'(0));
        check("drain_m", 32'(m), 32'(8'h22));
        check("drain_sel", 32'(sel), 32'(1));
        cycle("drain_idle");

        // reset mid-stream
        do_reset();
        for (int c = 0; c < N; c++) set_ch(c, 8'(8'h50 + c));
        drive(4'b1111, 1'b1);
        cycle("mid");
        cycle("mid");
        reset = 1'b1;
        drive(4'b1111, 1'b1);
        #1 check("mid_rst_rdy", 32'(rdy), 32'(0));
        cycle("mid_rst");
        reset = 1'b0;
        check("mid_mvalid", 32'(m_valid), 32'(0));
        check("mid_m", 32'(m), 32'(0));
        check("mid_sel", 32'(sel), 32'(0));
        drive(4'b1111, 1'b1);
        cycle("mid_after");
        check("mid_first_sel", 32'(sel), 32'(0));
        check("mid_first_m", 32'(m), 32'(8'h50));

        // two requesters held: fixed priority always picks 1
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(4'b1010, 1'b1);
            cycle("fix");
`ifndef MUX_RR_NCH_RR_EN
            check("fix_sel", 32'(sel), 32'(1));
`endif
        end

        // random traffic
        for (int i = 0; i < 400; i++) begin
            for (int c = 0; c < N; c++) set_ch(c, 8'($urandom_range(0, 255)));
            drive(N'($urandom_range(0, (1 << N) - 1)), 1'($urandom_range(0, 3) != 0));
            cycle("rand");
        end

        // flush remaining word
        drive('0, 1'b1);
        cycle("flush");
        cycle("flush");
        check("flush_sb_empty", 32'(exp_q.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
